fir_mc_serial: RTL and testbench
================================

# fir_mc_serial

Time-multiplexed, multi-channel serial FIR filter with an integrated controller. It computes one output per accepted input sample using a single multiplier-accumulator iterated over all taps. Each channel has its own delay line; all channels share one coefficient bank. It sits between an upstream sample source and a downstream consumer, with a valid/ready handshake on both sides and a runtime coefficient-write port.

## Interface
- IN_WIDTH, 8, signed sample and coefficient width
- TAPS, 8, filter length (≥2)
- CHANNELS, 2, number of independent delay lines (≥1)
- OUT_SHIFT, 0, arithmetic right shift applied to the accumulator before output, with rounding
- OUT_WIDTH, 16, signed output width; the result is saturated to this width
- Derived: CNT_W = $clog2(TAPS), CH_W = max(1, $clog2(CHANNELS)), ACC_W = 2*IN_WIDTH + CNT_W + 1

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_data  in  IN_WIDTH  signed sample
- in_ch  in  CH_W  channel of the sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  CNT_W  tap index
- coef_data  in  IN_WIDTH  signed coefficient
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  OUT_WIDTH  signed, rounded, saturated result
- out_ch  out  CH_W  channel of the result
- out_sat  out  1  out_data was clamped
- busy  out  1  state ≠ IDLE

## Operation
- States:
  - IDLE: in_ready=1. An accept (in_valid & in_ready) with in_ch < CHANNELS shifts delay line in_ch (tap0 ← in_data, tap[k] ← tap[k-1]), latches the channel, clears acc and k, and moves to MAC.
  - An accept with in_ch ≥ CHANNELS is consumed and dropped. The block stays in IDLE, no output is produced and no delay line changes.
  - MAC: each cycle acc ← acc + coef[k]*tap[ch][k], computed full-precision signed in ACC_W with no overflow possible. k increments each cycle; after k = TAPS-1 the state moves to OUT.
  - OUT: out_valid=1, with out_data, out_ch and out_sat held stable. When out_ready=1 the state returns to IDLE.
- Output arithmetic: r = (acc + (OUT_SHIFT>0 ? 1<<(OUT_SHIFT-1) : 0)) >>> OUT_SHIFT. If r exceeds the OUT_WIDTH range, out_data is clamped to 2^(OUT_WIDTH-1)-1 or -2^(OUT_WIDTH-1) and out_sat=1.
- Coefficient writes:
  - Honoured only while busy=0; coef[coef_addr] ← coef_data at the clock edge.
  - Writes while busy=1 are ignored.
  - A write and an accept in the same IDLE cycle: the write lands first, and the MAC uses the new coefficient.
- Delay lines of other channels are never disturbed by an accept on a given channel.

## Timing
- Reset values: in_ready=0 while reset is asserted, 1 after release. out_valid=0, out_data=0, out_ch=0, out_sat=0, busy=0.
- Reset clears all delay-line taps, acc and k to 0 and all coefficients to 0. State goes to IDLE.
- Accept at edge E0. MAC runs on edges E1..E_TAPS. out_valid rises after E_TAPS, giving a latency of TAPS cycles from accept to out_valid.
- Minimum sample period is TAPS+2 cycles, because in_ready is low from E0 until the OUT→IDLE edge.
- out_ready held low stalls indefinitely in OUT. Outputs stay stable and in_ready stays 0.
- Reset asserted mid-MAC or mid-OUT: immediate abort, with no out_valid pulse after release.
- out_valid is never asserted in IDLE or MAC.

## Test plan
- Coefficients 1..8 and TAPS=8. Feed impulse 1 followed by seven 0s on ch0, with out_ready=1 → out_data sequence 1,2,…,8, out_ch=0, out_sat=0. Each result arrives 8 cycles after its accept.
- Interleave ch0 impulse and ch1 constant 2, all coefficients 1 → ch1 outputs 2,4,…,16, with ch0 unaffected by ch1 samples.
- All coefficients 127, constant input 127, OUT_WIDTH=16 → the accumulator reaches 129032 and out_data=32767 with out_sat=1. Input -128 gives -32768 with out_sat=1.
- OUT_SHIFT=2: accumulator 6 → out_data 2; accumulator -6 → out_data -1.
- Hold out_ready=0 for 10 cycles in OUT → out_data stable and in_ready=0 throughout. A coef_we during that window is ignored, so a later read-back via impulse shows the old coefficient.
- Assert reset at MAC cycle 3 → immediate idle with all outputs 0. The next impulse yields 0 because coefficients were cleared. in_ch=CHANNELS is consumed with no output.

Source files
------------

// File: rtl/fir_mc_serial.sv
// Time-multiplexed multi-channel FIR: one shared MAC walks all taps of the selected
// channel per accepted sample. Per-channel delay lines, shared coefficient bank. Active-low async reset.
module fir_mc_serial #(
  parameter int IN_WIDTH  = 8,
  parameter int TAPS      = 8,
  parameter int CHANNELS  = 2,
  parameter int OUT_SHIFT = 0,
  parameter int OUT_WIDTH = 16,
  localparam int CNT_W = $clog2(TAPS),
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int ACC_W = 2*IN_WIDTH + CNT_W + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [CH_W-1:0]      in_ch,
  input  logic                 coef_we,
  input  logic [CNT_W-1:0]     coef_addr,
  input  logic [IN_WIDTH-1:0]  coef_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [CH_W-1:0]      out_ch,
  output logic                 out_sat,
  output logic                 busy
);

  // One guard bit above the accumulator so rounding and clamping never wrap.
  localparam int RW = (ACC_W + 1 > OUT_WIDTH) ? ACC_W + 1 : OUT_WIDTH + 1;
  localparam logic signed [RW-1:0] RND     = RW'((2 ** OUT_SHIFT) / 2);
  localparam logic signed [RW-1:0] SAT_MAX = (RW'(1) << (OUT_WIDTH - 1)) - RW'(1);
  localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [CNT_W-1:0]     K_LAST  = CNT_W'(TAPS - 1);
  localparam logic [CH_W:0]        CH_LIM  = (CH_W + 1)'(CHANNELS);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_k;
  logic [CH_W-1:0]         r_ch;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_out_valid;
  logic [OUT_WIDTH-1:0]    r_out_data;
  logic [CH_W-1:0]         r_out_ch;
  logic                    r_out_sat;

  logic                        w_accept;
  logic                        w_ch_ok;
  logic                        w_load;
  logic signed [IN_WIDTH-1:0]  w_ch_tap [CHANNELS];
  logic signed [IN_WIDTH-1:0]  w_coef_arr [TAPS];
  logic signed [IN_WIDTH-1:0]  w_tap;
  logic signed [IN_WIDTH-1:0]  w_coef;
  logic signed [2*IN_WIDTH-1:0] w_prod;
  logic signed [ACC_W-1:0]     w_acc_sum;
  logic signed [RW-1:0]        w_acc_ext;
  logic signed [RW-1:0]        w_rounded;
  logic                        w_sat_hi;
  logic                        w_sat_lo;
  logic [OUT_WIDTH-1:0]        w_out_data;

  assign in_ready  = reset && (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_sat   = r_out_sat;

  // Out-of-range channels are still accepted (handshake completes) but then discarded.
  assign w_accept = in_valid && in_ready;
  assign w_ch_ok  = ({1'b0, in_ch} < CH_LIM);
  assign w_load   = w_accept && w_ch_ok;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic signed [IN_WIDTH-1:0] r_line [TAPS];
      logic                       w_shift;

      assign w_shift = w_load && (in_ch == CH_W'(gi));

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int t = 0; t < TAPS; t++) r_line[t] <= '0;
        end else if (w_shift) begin
          r_line[0] <= $signed(in_data);
          for (int t = 1; t < TAPS; t++) r_line[t] <= r_line[t-1];
        end
      end

      assign w_ch_tap[gi] = r_line[r_k];
    end

    // Writes land only while idle, so a same-cycle accept already sees the new value.
    for (gi = 0; gi < TAPS; gi++) begin : g_coef
      logic signed [IN_WIDTH-1:0] r_coef;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_coef <= '0;
        end else if (coef_we && !busy && (coef_addr == CNT_W'(gi))) begin
          r_coef <= $signed(coef_data);
        end
      end

      assign w_coef_arr[gi] = r_coef;
    end
  endgenerate

  assign w_tap     = w_ch_tap[r_ch];
  assign w_coef    = w_coef_arr[r_k];
  assign w_prod    = w_coef * w_tap;
  assign w_acc_sum = r_acc + {{(ACC_W - 2*IN_WIDTH){w_prod[2*IN_WIDTH-1]}}, w_prod};
  assign w_acc_ext = {{(RW - ACC_W){w_acc_sum[ACC_W-1]}}, w_acc_sum};
  assign w_rounded = (w_acc_ext + RND) >>> OUT_SHIFT;
  assign w_sat_hi  = (w_rounded > SAT_MAX);
  assign w_sat_lo  = (w_rounded < SAT_MIN);
  assign w_out_data = w_sat_hi ? SAT_MAX[OUT_WIDTH-1:0] :
                      w_sat_lo ? SAT_MIN[OUT_WIDTH-1:0] :
                                 w_rounded[OUT_WIDTH-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_ch        <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            r_ch    <= in_ch;
            r_acc   <= '0;
            r_k     <= '0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= w_acc_sum;
          r_k   <= r_k + 1'b1;
          // Final product is folded in on the same edge that registers the result.
          if (r_k == K_LAST) begin
            r_state     <= S_OUT;
            r_out_valid <= 1'b1;
            r_out_data  <= w_out_data;
            r_out_ch    <= r_ch;
            r_out_sat   <= w_sat_hi || w_sat_lo;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mc_serial.sv
// Directed bench for fir_mc_serial: scoreboard of expected results, checked on each output handshake.
module tb_fir_mc_serial;
  localparam int IW   = 8;
  localparam int TAPS = 8;
  localparam int CH   = 3;
  localparam int CHW  = 2;
  localparam int CNTW = 3;
  localparam int OW   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n;

  logic                 in_valid, in_ready, coef_we, out_valid, out_ready, out_sat, busy;
  logic [IW-1:0]        in_data, coef_data;
  logic [CHW-1:0]       in_ch, out_ch;
  logic [CNTW-1:0]      coef_addr;
  logic signed [OW-1:0] out_data;

  logic                 b_in_valid, b_in_ready, b_coef_we, b_out_valid, b_out_ready, b_out_sat, b_busy;
  logic [IW-1:0]        b_in_data, b_coef_data;
  logic [0:0]           b_in_ch, b_out_ch;
  logic [CNTW-1:0]      b_coef_addr;
  logic signed [OW-1:0] b_out_data;

  fir_mc_serial #(.IN_WIDTH(IW), .TAPS(TAPS), .CHANNELS(CH), .OUT_SHIFT(0), .OUT_WIDTH(OW)) u_dut (
    .clk(clk), .reset(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ch(in_ch),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .out_sat(out_sat), .busy(busy)
  );

  fir_mc_serial #(.IN_WIDTH(IW), .TAPS(TAPS), .CHANNELS(2), .OUT_SHIFT(2), .OUT_WIDTH(OW)) u_dut_sh (
    .clk(clk), .reset(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ch(b_in_ch),
    .coef_we(b_coef_we), .coef_addr(b_coef_addr), .coef_data(b_coef_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ch(b_out_ch),
    .out_sat(b_out_sat), .busy(b_busy)
  );

  typedef struct {
    int data;
    int ch;
    int sat;
    int acc_cyc;
    bit lat;
  } sb_item_t;

  sb_item_t sb[$];
  int n_checks = 0;
  int n_errors = 0;
  int acc_cyc  = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wcoef(input int a, input int d);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = CNTW'(a);
    coef_data = IW'(d);
    @(posedge clk);
    #1 coef_we = 1'b0;
  endtask

  task automatic send(input int ch, input int data);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_before_send", in_ready, 1);
    in_valid = 1'b1;
    in_ch    = CHW'(ch);
    in_data  = IW'(data);
    @(posedge clk);
    #1 in_valid = 1'b0;
    acc_cyc = cyc;
    $display("send   ch=%0d data=%0d", ch, data);
  endtask

  task automatic expect_out(input int ch, input int data, input int sat, input bit lat);
    sb_item_t it;
    it.data    = data;
    it.ch      = ch;
    it.sat     = sat;
    it.acc_cyc = acc_cyc;
    it.lat     = lat;
    sb.push_back(it);
  endtask

  task automatic collect();
    int t;
    sb_item_t it;
    t = 0;
    while (!(out_valid === 1'b1 && out_ready === 1'b1) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("out_handshake", out_valid && out_ready, 1);
    chk("sb_pending", sb.size() > 0, 1);
    if (sb.size() > 0) begin
      it = sb.pop_front();
      chk("out_data", out_data, it.data);
      chk("out_ch", out_ch, it.ch);
      chk("out_sat", out_sat, it.sat);
      if (it.lat) chk("latency", cyc - it.acc_cyc, TAPS);
      $display("result ch=%0d data=%0d sat=%0d (expected %0d)", out_ch, out_data, out_sat, it.data);
    end
  endtask

  task automatic b_run(input int data, input int exp);
    int t;
    t = 0;
    @(negedge clk);
    b_in_valid = 1'b1;
    b_in_ch    = 1'b0;
    b_in_data  = IW'(data);
    @(posedge clk);
    #1 b_in_valid = 1'b0;
    while (!b_out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("b_out_valid", b_out_valid, 1);
    chk("b_out_data", b_out_data, exp);
    chk("b_out_sat", b_out_sat, 0);
    $display("shift  in=%0d result=%0d (expected %0d)", data, b_out_data, exp);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int exp_v;
    int exp_s;
    int seen;

    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_ch = '0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_ch = '0; b_coef_we = 1'b0; b_coef_addr = '0; b_coef_data = '0;
    b_out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_busy", busy, 0);

    // Impulse through coefficients 1..8 on ch0
    for (int k = 0; k < TAPS; k++) wcoef(k, k + 1);
    for (int j = 0; j < TAPS; j++) begin
      send(0, (j == 0) ? 1 : 0);
      expect_out(0, j + 1, 0, 1'b1);
      collect();
    end

    // Interleaved channels, all coefficients 1
    for (int k = 0; k < TAPS; k++) wcoef(k, 1);
    for (int i = 0; i < TAPS; i++) begin
      send(0, (i == 0) ? 1 : 0);
      expect_out(0, 1, 0, 1'b1);
      collect();
      send(1, 2);
      expect_out(1, 2 * (i + 1), 0, 1'b1);
      collect();
    end

    // Saturation on ch2, all coefficients 127
    for (int k = 0; k < TAPS; k++) wcoef(k, 127);
    for (int n = 1; n <= TAPS; n++) begin
      acc   = 127 * 127 * n;
      exp_v = (acc > 32767) ? 32767 : acc;
      exp_s = (acc > 32767) ? 1 : 0;
      send(2, 127);
      expect_out(2, exp_v, exp_s, 1'b1);
      collect();
    end
    for (int n = 1; n <= TAPS; n++) begin
      acc   = 127 * (127 * (TAPS - n) - 128 * n);
      exp_v = (acc > 32767) ? 32767 : (acc < -32768) ? -32768 : acc;
      exp_s = (acc > 32767 || acc < -32768) ? 1 : 0;
      send(2, -128);
      expect_out(2, exp_v, exp_s, 1'b1);
      collect();
    end

    // Rounding shift on the second instance: coef0 = 3
    @(negedge clk);
    b_coef_we = 1'b1; b_coef_addr = '0; b_coef_data = IW'(3);
    @(posedge clk);
    #1 b_coef_we = 1'b0;
    b_run(2, 2);
    b_run(-2, -1);
    b_run(3, 2);

    // Output stall with an ignored coefficient write
    for (int k = 0; k < TAPS; k++) wcoef(k, (k == 0) ? 4 : 0);
    out_ready = 1'b0;
    send(0, 3);
    expect_out(0, 12, 0, 1'b0);
    seen = 0;
    while (!out_valid && seen < 100) begin
      @(negedge clk);
      seen++;
    end
    chk("stall_valid", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_data", out_data, 12);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid_hold", out_valid, 1);
      if (i == 2) wcoef(0, 9);
    end
    @(negedge clk);
    out_ready = 1'b1;
    collect();
    send(0, 1);
    expect_out(0, 4, 0, 1'b1);
    collect();

    // Reset during MAC
    send(0, 5);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (TAPS + 4) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_output", seen, 0);
    send(0, 1);
    expect_out(0, 0, 0, 1'b1);
    collect();

    // Out-of-range channel is consumed without effect
    send(CH, 50);
    chk("drop_busy", busy, 0);
    chk("drop_in_ready", in_ready, 1);
    seen = 0;
    repeat (TAPS + 4) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("drop_no_output", seen, 0);
    wcoef(1, 1);
    send(0, 0);
    expect_out(0, 1, 0, 1'b1);
    collect();

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
